// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer states, branch types, opcodes and width defaults
package cpu_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int OP_W_DEF   = 32;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, ISSUE} state_t;
    localparam logic [1:0] BR_BZ  = 2'd0;
    localparam logic [1:0] BR_BNZ = 2'd1;
    localparam logic [1:0] BR_JMP = 2'd2;
    localparam logic [1:0] BR_JMR = 2'd3;
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_JMR = 5'd21;
    // Opcodes 16, 17 and 22..31 are unassigned
    function automatic logic is_illegal_op(input logic [4:0] opc);
        return opc == 5'd16 || opc == 5'd17 || opc >= 5'd22;
    endfunction
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: resolves branch/jump decoder outputs into the next program counter
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              j_i,
    input  logic [1:0]        br_type_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic [ADDR_W-1:0] jmr_target_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    logic taken;
    // Taken decision and target select; all additions wrap modulo 2^ADDR_W
    always_comb begin
        taken = j_i && (br_type_i == BR_JMP || br_type_i == BR_JMR ||
                        (br_type_i == BR_BZ && zero_i) || (br_type_i == BR_BNZ && !zero_i));
        next_pc_o = !taken ? pc_i + ADDR_W'(1) :
                    br_type_i == BR_JMR ? jmr_target_i : pc_i + offset_i;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / PC unit feeding control_unit; optional ILLEGAL_OP_TRAP_EN trap
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                OP_W         = OP_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [OP_W-1:0]   imem_data,
    input  logic              imem_ack,
    output logic [OP_W-1:0]   op,
    output logic [ADDR_W-1:0] address,
    output logic              op_valid,
    input  logic              J,
    input  logic [1:0]        BZ_BNZ_JMP_JMR,
    input  logic [15:0]       im_offset,
    input  logic              zero,
    input  logic [ADDR_W-1:0] jmr_target,
    output logic              halted
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic              illegal_op,
    output logic [ADDR_W-1:0] trap_addr
`endif
);
    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, imem_addr_q, address_q, npc;
    logic [OP_W-1:0]   op_q;
    logic              imem_rd_q, op_valid_q, halted_q;
    logic              trap_q, ack_ill;
    logic              unused_offset_hi;

    assign unused_offset_hi = ^im_offset[15:ADDR_W];

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_i        (pc_q),
        .j_i         (J),
        .br_type_i   (BZ_BNZ_JMP_JMR),
        .zero_i      (zero),
        .offset_i    (im_offset[ADDR_W-1:0]),
        .jmr_target_i(jmr_target),
        .next_pc_o   (npc)
    );

`ifdef ILLEGAL_OP_TRAP_EN
    logic [ADDR_W-1:0] trap_addr_q;
    assign ack_ill    = is_illegal_op(imem_data[31:27]);
    assign illegal_op = trap_q;
    assign trap_addr  = trap_addr_q;
    // Sticky trap flag and faulting pc, captured when the illegal word is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else if (state_q == WAIT && imem_ack && ack_ill) begin
            trap_q      <= 1'b1;
            trap_addr_q <= pc_q;
        end
    end
`else
    assign ack_ill = 1'b0;
    assign trap_q  = 1'b0;
`endif

    // Sequencer FSM; every output is registered so the decoder sees glitch-free levels
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_VECTOR;
            imem_addr_q <= RESET_VECTOR;
            address_q   <= RESET_VECTOR;
            imem_rd_q   <= 1'b0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (run && !trap_q) begin
                    state_q     <= FETCH;
                    imem_addr_q <= pc_q;
                    imem_rd_q   <= 1'b1;
                    halted_q    <= 1'b0;
                end
                FETCH: begin
                    state_q   <= WAIT;
                    imem_rd_q <= 1'b0;
                end
                WAIT: if (imem_ack) begin
                    state_q    <= ISSUE;
                    op_q       <= ack_ill ? '0 : imem_data;
                    address_q  <= pc_q;
                    op_valid_q <= 1'b1;
                end
                ISSUE: begin
                    op_valid_q <= 1'b0;
                    pc_q       <= npc;
                    if (run && !trap_q) begin
                        state_q     <= FETCH;
                        imem_addr_q <= npc;
                        imem_rd_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        halted_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem_addr = imem_addr_q;
    assign imem_rd   = imem_rd_q;
    assign op        = op_q;
    assign address   = address_q;
    assign op_valid  = op_valid_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with memory responder, reference next-pc model and random branches
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 0, reset = 1, run = 0;
    logic [7:0]  imem_addr, address, jmr_target = 0;
    logic        imem_rd, imem_ack = 0, op_valid, halted, J = 0, zero = 0;
    logic [31:0] imem_data = 0, op;
    logic [1:0]  br_type = 0;
    logic [15:0] im_offset = 0;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_op;
    logic [7:0]  trap_addr;
`endif

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_ack(imem_ack),
        .op(op), .address(address), .op_valid(op_valid),
        .J(J), .BZ_BNZ_JMP_JMR(br_type), .im_offset(im_offset), .zero(zero),
        .jmr_target(jmr_target), .halted(halted)
`ifdef ILLEGAL_OP_TRAP_EN
        , .illegal_op(illegal_op), .trap_addr(trap_addr)
`endif
    );

    typedef struct { logic [31:0] op; logic [7:0] a; } iss_t;

    logic [31:0] mem [256];
    iss_t        exp_q[$];
    iss_t        e;
    logic [7:0]  exp_pc = 0, last_addr = 0;
    logic [31:0] last_op = 0;
    int          vectors = 0, errors = 0, rd_count = 0, fixed_lat = 1;
    logic        mem_en = 1, rand_br = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Legal opcodes only: 0..15 and 18..21
    function automatic logic [31:0] rand_word();
        int k = $urandom_range(0, 19);
        logic [4:0] opc = 5'(k < 16 ? k : k + 2);
        return {opc, 27'($urandom)};
    endfunction

    // Reference model: next pc from the branch rules, using integer arithmetic mod 256
    function automatic logic [7:0] ref_next(input logic [7:0] pc, input logic j, input logic [1:0] t,
                                            input logic z, input logic [15:0] off, input logic [7:0] tgt);
        int p = int'(pc);
        int s = int'($signed(off));
        bit taken = j && (t == 2 || t == 3 || (t == 0 && z) || (t == 1 && !z));
        if (!taken) return 8'((p + 1) % 256);
        if (t == 3) return tgt;
        return 8'((p + s + 65536) % 256);
    endfunction

    function automatic logic [31:0] model_op(input logic [31:0] w);
`ifdef ILLEGAL_OP_TRAP_EN
        int opc = int'(w[31:27]);
        if (opc == 16 || opc == 17 || opc >= 22) return 32'h0;
`endif
        return w;
    endfunction

    // Instruction memory responder: checks fetch address, acks after a latency, queues the expected issue
    initial forever begin
        logic [7:0] a;
        int lat;
        @(negedge clk);
        if (imem_rd && mem_en && !reset) begin
            chk("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_pc});
            a = imem_addr;
            lat = fixed_lat > 0 ? fixed_lat : $urandom_range(1, 4);
            repeat (lat) @(posedge clk);
            #1;
            imem_ack = 1;
            imem_data = mem[a];
            exp_q.push_back('{model_op(mem[a]), a});
            @(posedge clk);
            #1;
            imem_ack = 0;
            imem_data = $urandom;
        end
    end

    // Monitor: pops expected issues on op_valid, otherwise requires op/address to hold
    always @(negedge clk) begin
        if (imem_rd) rd_count++;
        if (reset) begin
            exp_q.delete();
            exp_pc = 0;
            last_op = 0;
            last_addr = 0;
        end else if (op_valid) begin
            if (exp_q.size() == 0) chk("issue_unexpected", {31'h0, op_valid}, 32'h0);
            else begin
                e = exp_q.pop_front();
                chk("issue_op", op, e.op);
                chk("issue_addr", {24'h0, address}, {24'h0, e.a});
                exp_pc = ref_next(e.a, J, br_type, zero, im_offset, jmr_target);
            end
            last_op = op;
            last_addr = address;
        end else begin
            chk("op_stable", op, last_op);
            chk("addr_stable", {24'h0, address}, {24'h0, last_addr});
        end
    end

    // Random decoder inputs and run toggling, changed just after the clock edge
    always @(posedge clk) if (rand_br) begin
        #1;
        J = 1'($urandom);
        br_type = 2'($urandom);
        zero = 1'($urandom);
        im_offset = 16'($urandom);
        jmr_target = 8'($urandom);
        if ($urandom_range(0, 15) == 0) run = !run;
    end

    task automatic wait_rd(output logic [7:0] a);
        int n = 0;
        do begin @(negedge clk); n++; end while (!imem_rd && n < 100);
        if (!imem_rd) chk("rd_timeout", {31'h0, imem_rd}, 32'h1);
        a = imem_addr;
    endtask

    task automatic wait_iss(output int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (!op_valid && n < 100);
        if (!op_valid) chk("issue_timeout", {31'h0, op_valid}, 32'h1);
        c = int'($time / 10);
    endtask

    task automatic set_br(input logic j, input logic [1:0] t, input logic [15:0] off,
                          input logic z, input logic [7:0] tgt);
        J = j; br_type = t; im_offset = off; zero = z; jmr_target = tgt;
    endtask

    // Resolve the in-flight instruction with the given decoder inputs and check the next fetch
    task automatic br(input string nm, input logic j, input logic [1:0] t, input logic [15:0] off,
                      input logic z, input logic [7:0] tgt, input logic [7:0] want);
        int c;
        logic [7:0] a;
        set_br(j, t, off, z, tgt);
        wait_iss(c);
        wait_rd(a);
        chk(nm, {24'h0, a}, {24'h0, want});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int c0, c1, n;
        foreach (mem[i]) mem[i] = rand_word();
        repeat (3) @(negedge clk);
        chk("rst_imem_rd", {31'h0, imem_rd}, 32'h0);
        chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h1);
        chk("rst_op", op, 32'h0);
        chk("rst_address", {24'h0, address}, 32'h0);
        chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
        reset = 0;
        run = 1;
        wait_rd(a);   chk("seq_fetch0", {24'h0, a}, 32'h0);
        wait_iss(c0); chk("seq_addr0", {24'h0, address}, 32'h0);
        wait_rd(a);   chk("seq_fetch1", {24'h0, a}, 32'h1);
        wait_iss(c1); chk("seq_addr1", {24'h0, address}, 32'h1);
        chk("issue_period", 32'(c1 - c0), 32'd3);
        wait_rd(a);   chk("seq_fetch2", {24'h0, a}, 32'h2);
        br("jmr_z1",  1, BR_JMR, 16'h0000, 1, 8'h7A, 8'h7A);
        br("jmr_z0",  1, BR_JMR, 16'h0000, 0, 8'h10, 8'h10);
        br("bz_t",    1, BR_BZ,  16'h0005, 1, 8'h00, 8'h15);
        br("jmr_10a", 1, BR_JMR, 16'h0000, 0, 8'h10, 8'h10);
        br("bz_nt",   1, BR_BZ,  16'h0005, 0, 8'h00, 8'h11);
        br("jmr_10b", 1, BR_JMR, 16'h0000, 0, 8'h10, 8'h10);
        br("bnz_t",   1, BR_BNZ, 16'h0005, 0, 8'h00, 8'h15);
        br("jmr_10c", 1, BR_JMR, 16'h0000, 1, 8'h10, 8'h10);
        br("bnz_nt",  1, BR_BNZ, 16'h0005, 1, 8'h00, 8'h11);
        br("jmr_02",  1, BR_JMR, 16'h0000, 0, 8'h02, 8'h02);
        br("jmp_neg", 1, BR_JMP, 16'hFFFC, 0, 8'h00, 8'hFE);
        br("seq_ff",  0, BR_BZ,  16'h0000, 0, 8'h00, 8'hFF);
        @(negedge clk);
        fixed_lat = 5;
        br("wrap_ff", 0, BR_BZ,  16'h0000, 0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        run = 0;
        chk("hold_op", op, mem[8'hFF]);
        chk("hold_valid", {31'h0, op_valid}, 32'h0);
        wait_iss(c0);
        chk("late_addr", {24'h0, address}, 32'h0);
        chk("late_op", op, mem[8'h00]);
        repeat (4) @(negedge clk);
        chk("halt_after", {31'h0, halted}, 32'h1);
        n = rd_count;
        repeat (5) @(negedge clk);
        chk("no_rd_idle", 32'(rd_count), 32'(n));
        fixed_lat = 0;
        run = 1;
        wait_rd(a);
        chk("resume_pc", {24'h0, a}, 32'h1);
        rand_br = 1;
        repeat (1500) @(negedge clk);
        rand_br = 0;
        run = 0;
        n = 0;
        while (!halted && n < 50) begin @(negedge clk); n++; end
        chk("drain_halted", {31'h0, halted}, 32'h1);
        repeat (2) @(negedge clk);
        mem_en = 0;
        set_br(0, BR_BZ, 16'h0, 0, 8'h0);
        run = 1;
        wait_rd(a);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        run = 0;
        @(posedge clk); #1; imem_ack = 1; imem_data = 32'hDEADBEEF;
        @(posedge clk); #1; imem_ack = 0;
        repeat (4) begin
            @(negedge clk);
            chk("stray_op", op, 32'h0);
            chk("stray_addr", {24'h0, address}, 32'h0);
            chk("stray_valid", {31'h0, op_valid}, 32'h0);
            chk("stray_halted", {31'h0, halted}, 32'h1);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        mem_en = 1;
        fixed_lat = 1;
        mem[8'h33] = {5'd16, 27'h0123456};
        set_br(1, BR_JMR, 16'h0, 0, 8'h33);
        run = 1;
        wait_iss(c0);
        wait_iss(c1);
        chk("trap_op", op, 32'h0);
        chk("trap_issue_addr", {24'h0, address}, 32'h33);
        repeat (3) @(negedge clk);
        chk("trap_flag", {31'h0, illegal_op}, 32'h1);
        chk("trap_addr", {24'h0, trap_addr}, 32'h33);
        chk("trap_halted", {31'h0, halted}, 32'h1);
        n = rd_count;
        repeat (10) @(negedge clk);
        chk("trap_no_rd", 32'(rd_count), 32'(n));
        run = 0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and program-counter unit that supplies `op` and `address` to `control_unit`.
- Reads 32-bit instruction words from an external instruction memory over a request/acknowledge handshake.
- Holds each fetched word stable for the decoder and resolves the decoder's branch/jump outputs to choose the next PC.
- Sits between instruction memory and `control_unit`; it is the producing end of the `op`/`address` interface.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- OP_W, 32, instruction word width.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- run  input  1  1 = sequencer fetches and issues; 0 = park in IDLE after the current instruction.
- imem_addr  output  ADDR_W  instruction memory address.
- imem_rd  output  1  read request, single-cycle pulse.
- imem_data  input  OP_W  read data, valid when imem_ack=1.
- imem_ack  input  1  read complete, single cycle.
- op  output  OP_W  instruction word to control_unit.
- address  output  ADDR_W  PC of the word currently on `op`.
- op_valid  output  1  1-cycle pulse: `op` issued this cycle, branch inputs sampled.
- J  input  1  from decoder: current op is a branch/jump.
- BZ_BNZ_JMP_JMR  input  2  00 BZ, 01 BNZ, 10 JMP, 11 JMR.
- im_offset  input  16  signed PC-relative offset (op[18:3]).
- zero  input  1  ALU zero flag for the current op.
- jmr_target  input  ADDR_W  absolute target for JMR (register A low bits).
- halted  output  1  sequencer in IDLE.

Behaviour:
- Clocking and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_VECTOR, imem_addr=RESET_VECTOR, address=RESET_VECTOR, imem_rd=0, op=0 (NOP), op_valid=0, halted=1.
- States are IDLE, FETCH, WAIT, ISSUE.
- IDLE: halted=1. If run=1, go to FETCH next cycle.
- FETCH: imem_addr=pc, imem_rd=1 for exactly this cycle, then WAIT. An imem_ack seen in FETCH is ignored.
- WAIT: imem_rd=0. Stays until imem_ack=1. On ack: op<=imem_data, address<=pc, go to ISSUE. No timeout.
- ISSUE: op_valid=1 for this cycle only. J, BZ_BNZ_JMP_JMR, im_offset, zero and jmr_target are sampled combinationally this cycle, and next pc is registered.
- After ISSUE: go to FETCH if run=1, else IDLE.
- `op` and `address` stay stable from ISSUE until the next WAIT-ack. The decoder is level-sensitive, so there must be no glitch or reload without ack.
- Next pc when J=0: pc+1.
- Next pc when J=1, by branch type:
  - BZ: pc+offset if zero=1, else pc+1.
  - BNZ: pc+offset if zero=0, else pc+1.
  - JMP: pc+offset, always taken.
  - JMR: jmr_target, always taken.
- Offset arithmetic: im_offset[ADDR_W-1:0] is used as two's complement. Addition is modulo 2^ADDR_W, so wrap-around is silent: 0xFF+1=0x00, 0x02+0xFC=0xFE.
- Minimum throughput is 3 cycles per instruction (FETCH, WAIT with same-cycle ack, ISSUE). Each cycle of memory latency adds one.
- run falling in FETCH/WAIT: the current instruction still completes (ack, ISSUE, pc update), then the sequencer goes to IDLE. pc is preserved, and the next run=1 resumes at that pc.
- reset in any state returns to reset values next cycle. An outstanding imem_ack arriving afterwards lands in IDLE or FETCH and is ignored.
- Each FETCH has exactly one outstanding request.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: in ISSUE, an opcode op[31:27] in {16,17,22..31} is treated as illegal. The sequencer then:
  - forces the issued `op` to 0 (NOP) with op_valid=1;
  - sets sticky output `illegal_op`=1 and latches the faulting pc on output `trap_addr` [ADDR_W];
  - enters IDLE and ignores run.
- Only reset clears the trap. Reset values: illegal_op=0, trap_addr=0.
- Not defined: these ports are absent, and all opcodes are issued unchanged with no branch effect unless J=1.

Decomposition:
- Shared package `cpu_pkg`:
  - state enum (IDLE/FETCH/WAIT/ISSUE);
  - branch-type constants BR_BZ=0, BR_BNZ=1, BR_JMP=2, BR_JMR=3;
  - opcode constants (NOP=0 … JMR=21);
  - ADDR_W/OP_W defaults.
- One natural sub-module, `next_pc_calc`: combinational pc, J, type, zero, offset, jmr_target -> next pc. It is shared later by any prefetch logic.

Test Plan:
- Reset then run=1, memory returns ADD at 0x00, 0x01 with ack 1 cycle after rd: imem_addr 0x00, 0x01; op_valid pulses every 3 cycles; address 0x00 then 0x01.
- BZ at pc 0x10, im_offset=0x0005: with zero=1, next imem_addr=0x15; with zero=0, 0x11. BNZ mirrors this.
- JMP at 0x02 with offset 0xFFFC: next fetch 0xFE. Sequential run from 0xFF fetches 0x00 next.
- JMR with jmr_target=0x7A: next fetch 0x7A regardless of zero.
- imem_ack delayed 5 cycles, run dropped during WAIT: op stays at the previous word until ack; one ISSUE, then halted=1; run=1 later resumes at the saved pc. Reset asserted mid-WAIT, then a stray ack: op stays 0, address=0x00, no op_valid.
- With ILLEGAL_OP_TRAP_EN, opcode 16 at 0x33: op_valid with op=0, illegal_op=1, trap_addr=0x33, halted=1, and no further imem_rd despite run=1.
